// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with BOOT/RUN control and ROM handshake.
// Define PC_REDIRECT_BUF_EN for the one-entry pending redirect buffer.
module pc_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FETCH_WIDTH = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR =
    ADDR_WIDTH'(32'hbfc00000)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   exc_flag,
  input  logic [ADDR_WIDTH-1:0]  exc_addr,
  input  logic                   branch_flag,
  input  logic [ADDR_WIDTH-1:0]  branch_addr,
  input  logic                   rom_ready,
  output logic                   rom_en,
  output logic [3:0]             rom_write_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic [DATA_WIDTH-1:0]  rom_write_data,
  output logic [FETCH_WIDTH-1:0] fetch_mask,
  output logic                   addr_err
);

  localparam int unsigned GRP_B = FETCH_WIDTH * 4;
  localparam int unsigned OFF_W = $clog2(GRP_B);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(GRP_B);
  localparam logic [ADDR_WIDTH-1:0] BASE_M =
    ~(ADDR_WIDTH'(GRP_B - 1));

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  state_e                state_q;
  logic                  rom_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  pend_vld;
  logic                  accept;

  assign accept = rom_en_q & rom_ready;
  assign base   = addr_q & BASE_M;

`ifdef PC_REDIRECT_BUF_EN
  logic                  pend_vld_q;
  logic                  pend_exc_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;

  // Park a redirect that arrives while the ROM is back-pressuring
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q  <= 1'b0;
      pend_exc_q  <= 1'b0;
      pend_addr_q <= '0;
    end else if (accept) begin
      pend_vld_q <= 1'b0;
      pend_exc_q <= 1'b0;
    end else if (rom_en_q) begin
      if (exc_flag) begin
        pend_vld_q  <= 1'b1;
        pend_exc_q  <= 1'b1;
        pend_addr_q <= exc_addr;
      end else if (branch_flag &&
                   !(pend_vld_q && pend_exc_q)) begin
        pend_vld_q  <= 1'b1;
        pend_exc_q  <= 1'b0;
        pend_addr_q <= branch_addr;
      end
    end
  end

  assign pend_vld  = pend_vld_q;
  assign pend_addr = pend_addr_q;
`else
  assign pend_vld  = 1'b0;
  assign pend_addr = '0;
`endif

  // Pick the next fetch address; only an accepted request moves it
  always_comb begin
    addr_d = addr_q;
    if (accept) begin
      if (exc_flag) begin
        addr_d = exc_addr;
      end else if (pend_vld) begin
        addr_d = pend_addr;
      end else if (branch_flag) begin
        addr_d = branch_addr;
      end else if (!stall) begin
        addr_d = base + STEP;
      end
    end
  end

  // BOOT waits one edge after reset, then RUN fetches forever
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      rom_en_q <= 1'b0;
      addr_q   <= RESET_VECTOR;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q  <= RUN;
          rom_en_q <= 1'b1;
        end
        RUN: begin
          addr_q <= addr_d;
        end
      endcase
    end
  end

  generate
    if (OFF_W == 2) begin : g_one
      assign fetch_mask = '1;
    end else begin : g_multi
      logic [OFF_W-3:0] slot;
      assign slot = addr_q[OFF_W-1:2];
      for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_bit
        assign fetch_mask[i] = (32'(slot) <= 32'(i));
      end
    end
  endgenerate

  assign rom_en         = rom_en_q;
  assign rom_addr       = addr_q;
  assign rom_write_en   = 4'b0000;
  assign rom_write_data = '0;
  assign addr_err       = rom_en_q & (addr_q[1:0] != 2'b00);

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, fetch address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction memory data width.
REQ-003 SHALL have parameter FETCH_WIDTH, default 1, instructions per fetch group; legal values are 1, 2 and 4.
REQ-004 SHALL have parameter RESET_VECTOR, default 32'hbfc00000, first fetch address.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  pipeline holds; blocks sequential advance only.
REQ-008 exc_flag  in  1  exception redirect request.
REQ-009 exc_addr  in  ADDR_WIDTH  exception target.
REQ-010 branch_flag  in  1  branch redirect request.
REQ-011 branch_addr  in  ADDR_WIDTH  branch target.
REQ-012 rom_ready  in  1  memory accepts the current request this cycle.
REQ-013 rom_en  out  1  fetch request valid.
REQ-014 rom_write_en  out  4  constant 0.
REQ-015 rom_addr  out  ADDR_WIDTH  fetch address; also the PC of slot 0 or of the entry slot.
REQ-016 rom_write_data  out  DATA_WIDTH  constant 0.
REQ-017 fetch_mask  out  FETCH_WIDTH  valid instruction slots in the current group.
REQ-018 addr_err  out  1  current fetch address is misaligned.

Function
REQ-019 States SHALL be BOOT and RUN; reset enters BOOT; the first posedge with rst high moves BOOT to RUN and sets rom_en to 1; RUN is left only by reset.
REQ-020 accept SHALL equal rom_en & rom_ready.
REQ-021 rom_addr SHALL hold its value while rom_en=1 and rom_ready=0.
REQ-022 On a posedge in RUN with accept=1, rom_addr SHALL load the first matching item in this priority order: exc_addr when exc_flag=1; else the pending redirect (if one exists); else branch_addr when branch_flag=1; else, if stall=0, the group base plus FETCH_WIDTH*4; else hold.
REQ-023 The group base SHALL be rom_addr with its low log2(FETCH_WIDTH*4) bits cleared.
REQ-024 Sequential addition SHALL wrap modulo 2^ADDR_WIDTH.
REQ-025 A redirect SHALL take effect at the accepting edge even if stall=1.
REQ-026 When exc_flag and branch_flag are both asserted, exc_flag SHALL win and the branch SHALL be discarded.
REQ-027 fetch_mask bit i SHALL be 1 iff i >= rom_addr[log2(FETCH_WIDTH*4)-1:2]; for FETCH_WIDTH=1 fetch_mask is constant 1.
REQ-028 addr_err SHALL equal rom_en & (rom_addr[1:0] != 0), combinationally.
REQ-029 While addr_err=1, rom_en SHALL stay 1, so that the downstream stage raises the address error; the address still advances per REQ-022.
REQ-030 Latency: a redirect presented in the cycle of acceptance SHALL appear on rom_addr one cycle later.

Reset
REQ-031 While rst=0: rom_en=0, rom_addr=RESET_VECTOR, state=BOOT, pending redirect cleared; fetch_mask, addr_err and the constant outputs follow from these values.
REQ-032 Asserting rst mid-handshake SHALL abort the request immediately, without waiting for rom_ready.
REQ-033 Flags present during BOOT SHALL be ignored.

Configuration
REQ-034 Macro PC_REDIRECT_BUF_EN defined: a redirect seen while rom_en=1 and rom_ready=0 SHALL be captured in a one-entry pending register.
- A new exception overwrites any pending entry.
- A branch does not overwrite a pending exception.
- A branch overwrites a pending branch.
- The entry is applied at the next accept per REQ-022, then cleared.
REQ-035 Macro PC_REDIRECT_BUF_EN undefined: no pending register exists; redirects not coincident with accept SHALL be dropped, and requesters must hold their flag until accept.

Verification
REQ-036 FETCH_WIDTH=1; release rst, rom_ready=1 -> rom_en rises at the first posedge; rom_addr = bfc00000, bfc00004, bfc00008 on successive cycles.
REQ-037 FETCH_WIDTH=4; branch_addr=80000008 accepted -> rom_addr=80000008, fetch_mask=4'b1100; next accepted cycle -> rom_addr=80000010, fetch_mask=4'b1111.
REQ-038 stall=1, branch_flag=1, branch_addr=80001000 -> rom_addr=80001000 next cycle; with stall still 1 -> rom_addr holds 80001000.
REQ-039 PC_REDIRECT_BUF_EN defined; rom_ready=0 for 3 cycles; branch pulse (80000100) in cycle 1, exc pulse (bfc00380) in cycle 2; rom_ready=1 in cycle 4 -> rom_addr=bfc00380 in cycle 5. PC_REDIRECT_BUF_EN undefined, same stimulus -> rom_addr advances sequentially.
REQ-040 rom_addr=fffffffc, FETCH_WIDTH=1, accept -> rom_addr=00000000.
REQ-041 branch_addr=80000002 accepted -> addr_err=1 next cycle.
REQ-042 rst pulsed low while rom_ready=0 -> rom_en=0 and rom_addr=bfc00000 asynchronously.
